// File: rtl/line_pio_fifo_if.sv
// Avalon-MM slave bus between the Nios control processor and line_pio_fifo.
// The processor side uses the master modport; the peripheral uses the slave modport.
interface line_pio_fifo_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        read;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, read, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, read, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/line_pio_fifo.sv
// Line PIO with atomic output set/clear, strobed capture FIFO, sticky overflow
// and a level-threshold interrupt, all behind an Avalon-MM slave.
module line_pio_fifo #(
  parameter int                DATA_W    = 32,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] OUT_RESET = '0
) (
  input  logic              clk,
  input  logic              reset,
  line_pio_fifo_if.slave    avs,
  input  logic [DATA_W-1:0] in_port,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_port,
  output logic              irq
);

  localparam int LVL_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [2:0] {
    REG_DATA   = 3'd0,
    REG_FIFO   = 3'd1,
    REG_STATUS = 3'd2,
    REG_IRQCTL = 3'd3,
    REG_OUTSET = 3'd4,
    REG_OUTCLR = 3'd5
  } reg_e;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] out_q, out_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              irq_q, irq_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              irq_en_q, irq_en_d;
  logic [LVL_W-1:0]  thr_q, thr_d;

  reg_e reg_sel;
  logic wr, rd, fifo_empty, fifo_full, pop, flush, push, drop;

  assign reg_sel = reg_e'(avs.address);

  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    wr         = avs.chipselect && !avs.write_n;
    rd         = avs.chipselect && avs.read;
    fifo_empty = (level_q == '0);
    fifo_full  = (level_q == LVL_W'(DEPTH));
    pop        = rd && (reg_sel == REG_FIFO) && !fifo_empty;
    flush      = wr && (reg_sel == REG_STATUS) && avs.writedata[30];
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    push       = in_valid && (!fifo_full || pop) && !flush;
    drop       = in_valid && fifo_full && !pop && !flush;

    out_d    = out_q;
    ovf_d    = ovf_q;
    irq_en_d = irq_en_q;
    thr_d    = thr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    rdata_d  = '0;

    if (wr) begin
      unique case (reg_sel)
        REG_DATA:   out_d = avs.writedata[DATA_W-1:0];
        REG_STATUS: if (avs.writedata[31]) ovf_d = 1'b0;
        REG_IRQCTL: begin
          irq_en_d = avs.writedata[31];
          thr_d    = avs.writedata[LVL_W-1:0];
        end
        REG_OUTSET: out_d = out_q | avs.writedata[DATA_W-1:0];
        REG_OUTCLR: out_d = out_q & ~avs.writedata[DATA_W-1:0];
        default: ;
      endcase
    end

    if (drop) ovf_d = 1'b1;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
    end

    if (rd) begin
      unique case (reg_sel)
        REG_DATA:   rdata_d = 32'(in_port);
        REG_FIFO:   rdata_d = fifo_empty ? 32'd0 : 32'(mem[rd_ptr_q]);
        REG_STATUS: rdata_d = {ovf_q, fifo_full, fifo_empty, 29'd0} | 32'(level_q);
        REG_IRQCTL: rdata_d = {irq_en_q, 31'd0} | 32'(thr_q);
        default:    rdata_d = '0;
      endcase
    end

    // Built from registered state, so irq trails its cause by one cycle.
    irq_d = irq_en_q && ((level_q >= thr_q) || ovf_q);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      out_q    <= OUT_RESET;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      level_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      irq_en_q <= 1'b0;
      thr_q    <= '0;
    end else begin
      out_q    <= out_d;
      rdata_q  <= rdata_d;
      irq_q    <= irq_d;
      level_q  <= level_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      irq_en_q <= irq_en_d;
      thr_q    <= thr_d;
    end
  end

  // NOTE: the storage array has no reset; empty reads return 0, so stale contents never leak out.
  always_ff @(posedge clk) begin
    if (!reset && push) mem[wr_ptr_q] <= in_port;
  end

  assign out_port     = out_q;
  assign irq          = irq_q;
  assign avs.readdata = rdata_q;

endmodule

// File: tb/tb_line_pio_fifo.sv
// Directed bench for line_pio_fifo: a queue of pushed samples is the reference for
// every FIFO read; register and irq expectations are constants derived from the map.
module tb_line_pio_fifo;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] in_port;
  logic        in_valid;
  logic [31:0] out_port;
  logic        irq;

  line_pio_fifo_if bus ();

  line_pio_fifo #(.DATA_W(32), .DEPTH(16), .OUT_RESET(32'h0)) dut (
    .clk      (clk),
    .reset    (reset),
    .avs      (bus.slave),
    .in_port  (in_port),
    .in_valid (in_valid),
    .out_port (out_port),
    .irq      (irq)
  );

  always #5 clk = ~clk;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb [$];
  logic [31:0] rd_val;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [2:0] addr, input logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    bus.address    = addr;
    bus.writedata  = data;
    cycle();
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [2:0] addr, output logic [31:0] data);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = addr;
    cycle();
    data           = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic push(input logic [31:0] val);
    in_valid = 1'b1;
    in_port  = val;
    cycle();
    in_valid = 1'b0;
    sb.push_back(val);
  endtask

  // Holds read on the FIFO address for n consecutive cycles.
  task automatic pop_burst(input int n, input string tag);
    logic [31:0] exp;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 3'd1;
    for (int i = 0; i < n; i++) begin
      cycle();
      exp = (sb.size() != 0) ? sb.pop_front() : 32'd0;
      check(tag, bus.readdata, exp);
    end
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  task automatic check_reg(input logic [2:0] addr, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    bus_read(addr, v);
    check(tag, v, exp);
  endtask

  initial begin
    reset          = 1'b1;
    in_valid       = 1'b1;
    in_port        = 32'h5555_5555;
    bus.address    = '0;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // Reset held three cycles with in_valid high
    repeat (3) cycle();
    check("rst_readdata", bus.readdata, 32'h0);
    check("rst_irq", {31'd0, irq}, 32'h0);
    check("rst_out_port", out_port, 32'h0);
    reset    = 1'b0;
    in_valid = 1'b0;
    check_reg(3'd2, 32'h2000_0000, "rst_status");
    check_reg(3'd3, 32'h0, "rst_irqctl");

    // DATA register
    bus_write(3'd0, 32'hA5A5_0F0F);
    check("data_out_port", out_port, 32'hA5A5_0F0F);
    in_port = 32'h1234_5678;
    check_reg(3'd0, 32'h1234_5678, "data_in_port");

    // Atomic set / clear
    bus_write(3'd0, 32'h0000_00F0);
    bus_write(3'd4, 32'h0000_000F);
    check("outset", out_port, 32'h0000_00FF);
    bus_write(3'd5, 32'h0000_0030);
    check("outclr", out_port, 32'h0000_00CF);
    check_reg(3'd4, 32'h0, "outset_reads0");
    check_reg(3'd6, 32'h0, "reserved_reads0");

    // FIFO order and wrap
    for (int i = 1; i <= 16; i++) push(32'(i));
    check_reg(3'd2, 32'h4000_0010, "fifo_full_status");
    for (int i = 0; i < 8; i++) begin
      bus_read(3'd1, rd_val);
      check("fifo_pop8", rd_val, sb.pop_front());
    end
    for (int i = 17; i <= 24; i++) push(32'(i));
    pop_burst(16, "fifo_wrap_burst");
    check_reg(3'd2, 32'h2000_0000, "fifo_drained_status");
    pop_burst(1, "fifo_empty_read");
    check_reg(3'd2, 32'h2000_0000, "fifo_empty_level0");

    // Overflow and simultaneous push/pop
    for (int i = 0; i < 16; i++) push(32'h100 + 32'(i));
    in_valid = 1'b1;
    in_port  = 32'h0000_DEAD;
    cycle();
    in_valid = 1'b0;
    check_reg(3'd2, 32'hC000_0010, "ovf_set");
    bus_write(3'd2, 32'h8000_0000);
    check_reg(3'd2, 32'h4000_0010, "ovf_cleared");
    in_valid = 1'b1;
    in_port  = 32'h0000_BEEF;
    bus_read(3'd1, rd_val);
    in_valid = 1'b0;
    check("pushpop_head", rd_val, sb.pop_front());
    sb.push_back(32'h0000_BEEF);
    check_reg(3'd2, 32'h4000_0010, "pushpop_no_ovf");
    pop_burst(16, "ovf_drain");

    // Level-threshold interrupt
    bus_write(3'd3, 32'h8000_0004);
    check_reg(3'd3, 32'h8000_0004, "irqctl_readback");
    check("irq_below_thr", {31'd0, irq}, 32'h0);
    for (int i = 0; i < 3; i++) push(32'h200 + 32'(i));
    cycle();
    check("irq_level3", {31'd0, irq}, 32'h0);
    push(32'h203);
    check("irq_latency", {31'd0, irq}, 32'h0);
    cycle();
    check("irq_level4", {31'd0, irq}, 32'h1);
    bus_read(3'd1, rd_val);
    check("irq_pop_data", rd_val, sb.pop_front());
    check("irq_pop_latency", {31'd0, irq}, 32'h1);
    cycle();
    check("irq_after_pop", {31'd0, irq}, 32'h0);

    // Overflow asserts irq regardless of level
    bus_write(3'd3, 32'h8000_001F);
    for (int i = 0; i < 13; i++) push(32'h300 + 32'(i));
    cycle();
    check("irq_full_no_ovf", {31'd0, irq}, 32'h0);
    in_valid = 1'b1;
    in_port  = 32'h0000_DEAD;
    cycle();
    in_valid = 1'b0;
    cycle();
    check("irq_on_ovf", {31'd0, irq}, 32'h1);

    // Threshold 0 keeps irq asserted with an empty FIFO
    bus_write(3'd2, 32'h8000_0000);
    bus_write(3'd3, 32'h8000_0000);
    bus_write(3'd2, 32'h4000_0000);
    sb.delete();
    cycle();
    check("irq_thr0_a", {31'd0, irq}, 32'h1);
    cycle();
    check("irq_thr0_b", {31'd0, irq}, 32'h1);

    // Flush wins over a simultaneous push
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(i));
    check_reg(3'd2, 32'h0000_0005, "pre_flush_level5");
    in_valid = 1'b1;
    in_port  = 32'h0000_0077;
    bus_write(3'd2, 32'h4000_0000);
    in_valid = 1'b0;
    sb.delete();
    check_reg(3'd2, 32'h2000_0000, "flush_empty");
    pop_burst(1, "flush_no_sample");

    // Reset in the middle of a pop burst
    for (int i = 0; i < 6; i++) push(32'h500 + 32'(i));
    check("pre_reset_irq", {31'd0, irq}, 32'h1);
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    bus.address    = 3'd1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("burst_pre_reset", bus.readdata, sb.pop_front());
    end
    reset = 1'b1;
    cycle();
    check("midrst_readdata", bus.readdata, 32'h0);
    check("midrst_irq", {31'd0, irq}, 32'h0);
    check("midrst_out_port", out_port, 32'h0);
    reset          = 1'b0;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
    sb.delete();
    check_reg(3'd2, 32'h2000_0000, "post_rst_status");
    check_reg(3'd3, 32'h0, "post_rst_irqctl");
    pop_burst(1, "post_rst_fifo");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
